// File: rtl/conv_operand_loader_if.sv
// Bus bundle between the convolution operand loader, its controller, the two
// operand SRAMs and the MAC bank.
interface conv_operand_loader_if #(
    parameter int IFM_AW = 12,
    parameter int WGT_AW = 10
);
    logic              iStart;
    logic              iClear;
    logic [15:0]       iNumTile;
    logic [IFM_AW-1:0] iIfmBase;
    logic [WGT_AW-1:0] iWgtBase;

    logic              oIfmRdEn;
    logic [IFM_AW-1:0] oIfmRdAddr;
    logic [127:0]      iIfmRdData;
    logic              oWgtRdEn;
    logic [WGT_AW-1:0] oWgtRdAddr;
    logic [72:0]       iWgtRdData;

    logic [127:0] oDin0, oDin1, oDin2, oDin3, oDin4, oDin5, oDin6, oDin7;
    logic [72:0]  oWeight0, oWeight1, oWeight2, oWeight3;
    logic [72:0]  oWeight4, oWeight5, oWeight6, oWeight7;
    logic         vld_o;
    logic         oBusy;
    logic         oDone;

    // Loader side.
    modport master (
        input  iStart, iClear, iNumTile, iIfmBase, iWgtBase,
        input  iIfmRdData, iWgtRdData,
        output oIfmRdEn, oIfmRdAddr, oWgtRdEn, oWgtRdAddr,
        output oDin0, oDin1, oDin2, oDin3, oDin4, oDin5, oDin6, oDin7,
        output oWeight0, oWeight1, oWeight2, oWeight3,
        output oWeight4, oWeight5, oWeight6, oWeight7,
        output vld_o, oBusy, oDone
    );

    // Controller / SRAM / MAC side.
    modport slave (
        output iStart, iClear, iNumTile, iIfmBase, iWgtBase,
        output iIfmRdData, iWgtRdData,
        input  oIfmRdEn, oIfmRdAddr, oWgtRdEn, oWgtRdAddr,
        input  oDin0, oDin1, oDin2, oDin3, oDin4, oDin5, oDin6, oDin7,
        input  oWeight0, oWeight1, oWeight2, oWeight3,
        input  oWeight4, oWeight5, oWeight6, oWeight7,
        input  vld_o, oBusy, oDone
    );
endinterface

// File: rtl/conv_operand_loader.sv
// Loads 8 weight words once, then per tile 8 ifmap words, and presents them as
// one operand set to the MAC bank with a single-cycle valid pulse.
module conv_operand_loader #(
    parameter int IFM_AW = 12,
    parameter int WGT_AW = 10
) (
    input logic                   clk,
    input logic                   rstn,
    conv_operand_loader_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WLOAD = 2'd1,
        FETCH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state, stateNext;
    logic [2:0]        k, kNext;
    logic [15:0]       t, tNext;
    logic [15:0]       numTile;
    logic [IFM_AW-1:0] ifmBase;
    logic [WGT_AW-1:0] wgtBase;
    logic              startHit;
    logic              lastTile;
    logic              ifmRdEn;
    logic              wgtRdEn;

    logic              capEn;
    logic              capIsWgt;
    logic [2:0]        capIdx;

    logic [127:0]      dinShadow [8];
    logic [72:0]       wgtShadow [8];
    logic [127:0]      din       [8];
    logic [72:0]       weight    [8];
    logic              vld;
    logic              done;
    logic              busy;

    assign lastTile = (17'(t) + 17'd1) >= 17'(numTile);

    always_comb begin
        // NOTE: every signal gets a default first so no path can leave one
        // unassigned, which would otherwise infer a latch.
        stateNext = state;
        kNext     = k;
        tNext     = t;
        ifmRdEn   = 1'b0;
        wgtRdEn   = 1'b0;
        startHit  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.iStart) begin
                    startHit = 1'b1;
                    kNext    = 3'd0;
                    tNext    = 16'd0;
                    if (bus.iNumTile != 16'd0) stateNext = WLOAD;
                end
            end
            WLOAD: begin
                wgtRdEn = 1'b1;
                kNext   = k + 3'd1;
                if (k == 3'd7) stateNext = FETCH;
            end
            FETCH: begin
                ifmRdEn = 1'b1;
                kNext   = k + 3'd1;
                if (k == 3'd7) stateNext = DRAIN;
            end
            DRAIN: begin
                kNext     = 3'd0;
                tNext     = t + 16'd1;
                stateNext = lastTile ? IDLE : FETCH;
            end
            default: stateNext = IDLE;
        endcase
        if (bus.iClear) begin
            stateNext = IDLE;
            kNext     = 3'd0;
            startHit  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            k     <= 3'd0;
            t     <= 16'd0;
        end else begin
            state <= stateNext;
            k     <= kNext;
            t     <= tNext;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            numTile <= 16'd0;
            ifmBase <= '0;
            wgtBase <= '0;
        end else if (startHit) begin
            numTile <= bus.iNumTile;
            ifmBase <= bus.iIfmBase;
            wgtBase <= bus.iWgtBase;
        end
    end

    assign bus.oWgtRdEn   = wgtRdEn;
    assign bus.oIfmRdEn   = ifmRdEn;
    assign bus.oWgtRdAddr = wgtBase + WGT_AW'(k);
    // {t,k} is 8*t+k; truncation to IFM_AW gives the intended silent wrap.
    assign bus.oIfmRdAddr = ifmBase + IFM_AW'({t, k});

    // Read data returns one cycle after the request, so the slot it belongs to
    // is remembered for exactly one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            capEn    <= 1'b0;
            capIsWgt <= 1'b0;
            capIdx   <= 3'd0;
        end else begin
            capEn    <= (ifmRdEn || wgtRdEn) && !bus.iClear;
            capIsWgt <= wgtRdEn;
            capIdx   <= k;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the shadow arrays are reset explicitly because operands
            // must read back as zero after reset, even before any load.
            for (int i = 0; i < 8; i++) begin
                dinShadow[i] <= '0;
                wgtShadow[i] <= '0;
            end
        end else if (capEn && !bus.iClear) begin
            if (capIsWgt) wgtShadow[capIdx] <= bus.iWgtRdData;
            else          dinShadow[capIdx] <= bus.iIfmRdData;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 8; i++) begin
                din[i]    <= '0;
                weight[i] <= '0;
            end
            vld  <= 1'b0;
            done <= 1'b0;
        end else begin
            vld  <= 1'b0;
            done <= 1'b0;
            if (state == DRAIN && !bus.iClear) begin
                // The slot-7 ifmap word is still on the read bus during DRAIN.
                for (int i = 0; i < 7; i++) din[i] <= dinShadow[i];
                din[7] <= bus.iIfmRdData;
                for (int i = 0; i < 8; i++) weight[i] <= wgtShadow[i];
                vld  <= 1'b1;
                done <= lastTile;
            end else if (startHit && bus.iNumTile == 16'd0) begin
                done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)             busy <= 1'b0;
        else if (bus.iClear)   busy <= 1'b0;
        else if (startHit)     busy <= 1'b1;
        else if (done)         busy <= 1'b0;
    end

    assign bus.vld_o = vld;
    assign bus.oDone = done;
    assign bus.oBusy = busy;

    assign bus.oDin0 = din[0];
    assign bus.oDin1 = din[1];
    assign bus.oDin2 = din[2];
    assign bus.oDin3 = din[3];
    assign bus.oDin4 = din[4];
    assign bus.oDin5 = din[5];
    assign bus.oDin6 = din[6];
    assign bus.oDin7 = din[7];

    assign bus.oWeight0 = weight[0];
    assign bus.oWeight1 = weight[1];
    assign bus.oWeight2 = weight[2];
    assign bus.oWeight3 = weight[3];
    assign bus.oWeight4 = weight[4];
    assign bus.oWeight5 = weight[5];
    assign bus.oWeight6 = weight[6];
    assign bus.oWeight7 = weight[7];

endmodule

// File: tb/tb_conv_operand_loader.sv
// Directed bench for conv_operand_loader: a schedule-level model predicts every
// output each cycle, and literal checks pin addresses, latency and data.
module tb_conv_operand_loader;
    localparam int IFM_AW = 12;
    localparam int WGT_AW = 10;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    conv_operand_loader_if #(.IFM_AW(IFM_AW), .WGT_AW(WGT_AW)) bus ();
    conv_operand_loader #(.IFM_AW(IFM_AW), .WGT_AW(WGT_AW)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int nTests = 0;
    int nFail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] ifmWord(input logic [IFM_AW-1:0] a);
        logic [31:0] w;
        w = 32'(a);
        return {w, ~w, w ^ 32'hDEAD_BEEF, w + 32'h0000_1234};
    endfunction

    function automatic logic [72:0] wgtWord(input logic [WGT_AW-1:0] a);
        logic [31:0] w;
        w = 32'(a);
        return {9'h155, w, ~w};
    endfunction

    logic [127:0] din [8];
    logic [72:0]  wgt [8];
    assign din[0] = bus.oDin0;  assign din[1] = bus.oDin1;
    assign din[2] = bus.oDin2;  assign din[3] = bus.oDin3;
    assign din[4] = bus.oDin4;  assign din[5] = bus.oDin5;
    assign din[6] = bus.oDin6;  assign din[7] = bus.oDin7;
    assign wgt[0] = bus.oWeight0; assign wgt[1] = bus.oWeight1;
    assign wgt[2] = bus.oWeight2; assign wgt[3] = bus.oWeight3;
    assign wgt[4] = bus.oWeight4; assign wgt[5] = bus.oWeight5;
    assign wgt[6] = bus.oWeight6; assign wgt[7] = bus.oWeight7;

    // SRAM stand-ins: answer one cycle after a request, junk otherwise.
    logic [IFM_AW-1:0] ifmLog [$];
    logic [WGT_AW-1:0] wgtLog [$];
    logic              pIfm, pWgt;
    logic [IFM_AW-1:0] pIfmA;
    logic [WGT_AW-1:0] pWgtA;

    initial begin
        bus.iIfmRdData = '0;
        bus.iWgtRdData = '0;
        forever begin
            @(negedge clk);
            pIfm  = bus.oIfmRdEn;
            pIfmA = bus.oIfmRdAddr;
            pWgt  = bus.oWgtRdEn;
            pWgtA = bus.oWgtRdAddr;
            if (pIfm) ifmLog.push_back(pIfmA);
            if (pWgt) wgtLog.push_back(pWgtA);
            @(posedge clk);
            #1;
            bus.iIfmRdData = pIfm ? ifmWord(pIfmA) : {4{$urandom()}};
            bus.iWgtRdData = pWgt ? wgtWord(pWgtA) : {$urandom(), $urandom(), 9'h0AA};
        end
    end

    // Model: after an accepted start at cycle 0, weights are read in cycles
    // 1..8, tile j reads in cycles 9+9j..16+9j, its operand set appears at 18+9j.
    bit                active = 1'b0;
    int                rel, mN, endRel, j, p;
    logic [IFM_AW-1:0] mIfm;
    logic [WGT_AW-1:0] mWgt;
    logic [127:0]      expDin [8];
    logic [72:0]       expWgt [8];
    logic              eW, eI, eV, eD, eB;
    logic [IFM_AW-1:0] eIA;
    logic [WGT_AW-1:0] eWA;

    initial for (int n = 0; n < 8; n++) begin
        expDin[n] = '0;
        expWgt[n] = '0;
    end

    always @(negedge clk) begin
        eW = 1'b0; eI = 1'b0; eV = 1'b0; eD = 1'b0; eB = 1'b0;
        eIA = '0; eWA = '0;
        endRel = (mN == 0) ? 1 : 18 + 9 * (mN - 1);
        if (!rstn) begin
            active = 1'b0;
            for (int n = 0; n < 8; n++) begin
                expDin[n] = '0;
                expWgt[n] = '0;
            end
        end else if (active) begin
            rel++;
            eB = (rel >= 1) && (rel <= endRel);
            eD = (rel == endRel);
            if (mN > 0) begin
                if (rel >= 1 && rel <= 8) begin
                    eW  = 1'b1;
                    eWA = mWgt + WGT_AW'(rel - 1);
                end
                if (rel >= 9) begin
                    j = (rel - 9) / 9;
                    p = (rel - 9) % 9;
                    if (j < mN && p < 8) begin
                        eI  = 1'b1;
                        eIA = mIfm + IFM_AW'(8 * j + p);
                    end
                end
                if (rel >= 18 && (rel - 18) % 9 == 0 && (rel - 18) / 9 < mN) begin
                    eV = 1'b1;
                    j  = (rel - 18) / 9;
                    for (int n = 0; n < 8; n++) begin
                        expDin[n] = ifmWord(mIfm + IFM_AW'(8 * j + n));
                        expWgt[n] = wgtWord(mWgt + WGT_AW'(n));
                    end
                end
            end
        end
        check("vld_o", bus.vld_o, eV);
        check("oDone", bus.oDone, eD);
        check("oBusy", bus.oBusy, eB);
        check("oWgtRdEn", bus.oWgtRdEn, eW);
        check("oIfmRdEn", bus.oIfmRdEn, eI);
        if (eW) check("oWgtRdAddr", bus.oWgtRdAddr, eWA);
        if (eI) check("oIfmRdAddr", bus.oIfmRdAddr, eIA);
        for (int n = 0; n < 8; n++) begin
            check($sformatf("oDin%0d", n), din[n], expDin[n]);
            check($sformatf("oWeight%0d", n), wgt[n], expWgt[n]);
        end
        if (rstn) begin
            if (bus.iClear) active = 1'b0;
            else if ((!active || rel >= endRel) && bus.iStart) begin
                active = 1'b1;
                rel    = 0;
                mN     = int'(bus.iNumTile);
                mIfm   = bus.iIfmBase;
                mWgt   = bus.iWgtBase;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic startSeq(input logic [15:0] n, input logic [IFM_AW-1:0] ib,
                            input logic [WGT_AW-1:0] wb);
        ifmLog.delete();
        wgtLog.delete();
        bus.iStart   = 1'b1;
        bus.iNumTile = n;
        bus.iIfmBase = ib;
        bus.iWgtBase = wb;
        tick();
        bus.iStart   = 1'b0;
        bus.iNumTile = 16'hFFFF;
        bus.iIfmBase = '1;
        bus.iWgtBase = '1;
    endtask

    task automatic waitVld(output int cyc);
        cyc = 1;
        while (!bus.vld_o && cyc < 200) begin
            tick();
            cyc++;
        end
        check("vld_o_seen", bus.vld_o, 1'b1);
    endtask

    task automatic waitDone();
        int cyc;
        cyc = 0;
        while (!bus.oDone && cyc < 400) begin
            tick();
            cyc++;
        end
        check("oDone_seen", bus.oDone, 1'b1);
    endtask

    int lat;

    initial begin
        bus.iStart   = 1'b0;
        bus.iClear   = 1'b0;
        bus.iNumTile = '0;
        bus.iIfmBase = '0;
        bus.iWgtBase = '0;
        #1 rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // Single tile.
        startSeq(16'd1, 12'h100, 10'h010);
        waitVld(lat);
        check("t1_latency", lat, 18);
        check("t1_done_with_vld", bus.oDone, 1'b1);
        repeat (3) tick();
        check("t1_wgt_reads", wgtLog.size(), 8);
        check("t1_wgt_first", wgtLog[0], 10'h010);
        check("t1_wgt_last", wgtLog[7], 10'h017);
        check("t1_ifm_reads", ifmLog.size(), 8);
        check("t1_ifm_first", ifmLog[0], 12'h100);
        check("t1_ifm_last", ifmLog[7], 12'h107);
        check("t1_din3_lit", bus.oDin3, 128'h00000103_FFFFFEFC_DEADBFEC_00001337);
        check("t1_weight5_lit", bus.oWeight5, {9'h155, 32'h0000_0015, 32'hFFFF_FFEA});

        // Three tiles.
        startSeq(16'd3, 12'h100, 10'h020);
        waitVld(lat);
        check("t3_lat0", lat, 18);
        check("t3_done0", bus.oDone, 1'b0);
        tick();
        waitVld(lat);
        check("t3_lat1", lat, 9);
        check("t3_done1", bus.oDone, 1'b0);
        tick();
        waitVld(lat);
        check("t3_lat2", lat, 9);
        check("t3_done2", bus.oDone, 1'b1);
        check("t3_din0_lit", bus.oDin0, 128'h00000110_FFFFFEEF_DEADBFFF_00001344);
        repeat (5) tick();
        check("t3_ifm_reads", ifmLog.size(), 24);
        check("t3_ifm_tile2", ifmLog[16], 12'h110);

        // Address wrap on the second tile.
        startSeq(16'd2, 12'hFF8, 10'h000);
        waitDone();
        repeat (2) tick();
        check("wrap_last_tile0", ifmLog[7], 12'hFFF);
        check("wrap_first_tile1", ifmLog[8], 12'h000);
        check("wrap_last_tile1", ifmLog[15], 12'h007);

        // Zero tiles.
        startSeq(16'd0, 12'h123, 10'h045);
        check("zero_done", bus.oDone, 1'b1);
        repeat (25) tick();
        check("zero_ifm_reads", ifmLog.size(), 0);
        check("zero_wgt_reads", wgtLog.size(), 0);

        // Abort during the second tile's fetch.
        startSeq(16'd4, 12'h200, 10'h040);
        repeat (19) tick();
        bus.iClear = 1'b1;
        tick();
        bus.iClear = 1'b0;
        check("clr_busy", bus.oBusy, 1'b0);
        check("clr_rden", bus.oIfmRdEn, 1'b0);
        repeat (30) tick();
        check("clr_ifm_reads", ifmLog.size(), 11);
        check("clr_din0_lit", bus.oDin0, 128'h00000200_FFFFFDFF_DEADBCEF_00001434);
        startSeq(16'd1, 12'h300, 10'h050);
        waitVld(lat);
        check("clr_restart_lat", lat, 18);
        repeat (2) tick();

        // Start while busy is ignored.
        startSeq(16'd2, 12'h400, 10'h080);
        repeat (4) tick();
        bus.iStart   = 1'b1;
        bus.iNumTile = 16'd9;
        bus.iIfmBase = 12'h7F0;
        bus.iWgtBase = 10'h3F0;
        tick();
        bus.iStart = 1'b0;
        waitDone();
        repeat (20) tick();
        check("ign_wgt_reads", wgtLog.size(), 8);
        check("ign_wgt_last", wgtLog[7], 10'h087);
        check("ign_ifm_reads", ifmLog.size(), 16);
        check("ign_ifm_last", ifmLog[15], 12'h40F);

        // Reset in the middle of the weight load.
        startSeq(16'd2, 12'h500, 10'h0C0);
        repeat (3) tick();
        #1 rstn = 1'b0;
        #1;
        check("rst_busy", bus.oBusy, 1'b0);
        check("rst_wgt_en", bus.oWgtRdEn, 1'b0);
        check("rst_din0", bus.oDin0, '0);
        check("rst_weight0", bus.oWeight0, '0);
        repeat (2) tick();
        rstn = 1'b1;
        repeat (10) tick();
        check("rst_idle_busy", bus.oBusy, 1'b0);
        startSeq(16'd1, 12'h600, 10'h0D0);
        waitVld(lat);
        check("rst_restart_lat", lat, 18);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule

// File: doc/conv_operand_loader.md
CONV_OPERAND_LOADER -- requirements
Module: conv_operand_loader

Interface
REQ-001 Parameters SHALL be: IFM_AW, default 12, input-feature-map SRAM address width.
REQ-002 Parameters SHALL be: WGT_AW, default 10, weight SRAM address width.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, per the ports below.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 iStart  in  1  start request; sampled only in IDLE.
REQ-007 iClear  in  1  synchronous abort.
REQ-008 iNumTile  in  16  tile count; captured at start.
REQ-009 iIfmBase  in  IFM_AW  ifmap base address; captured at start.
REQ-010 iWgtBase  in  WGT_AW  weight base address; captured at start.
REQ-011 oIfmRdEn / oIfmRdAddr  out  1 / IFM_AW  ifmap SRAM read request.
REQ-012 iIfmRdData  in  128  ifmap read data; valid exactly 1 cycle after request.
REQ-013 oWgtRdEn / oWgtRdAddr  out  1 / WGT_AW  weight SRAM read request.
REQ-014 iWgtRdData  in  73  weight read data; valid exactly 1 cycle after request.
REQ-015 oDin0..oDin7  out  128 each  per-channel 16-pixel operand to MAC bank.
REQ-016 oWeight0..oWeight7  out  73 each  per-channel weight word to MAC bank.
REQ-017 vld_o  out  1  one-cycle pulse: operand set valid.
REQ-018 oBusy / oDone  out  1 / 1  sequence active / one-cycle completion pulse.

Function
REQ-019 FSM states SHALL be IDLE, WLOAD, FETCH, DRAIN; counters k (3 bit, channel) and t (16 bit, tile).
REQ-020 IDLE: iStart=1 captures bases and iNumTile, clears k and t; next state WLOAD, or IDLE with oDone pulse next cycle if iNumTile=0 (no reads issued).
REQ-021 WLOAD: each cycle oWgtRdEn=1, oWgtRdAddr=wgtBase+k; k increments; after k=7 go to FETCH with k=0.
REQ-022 FETCH: each cycle oIfmRdEn=1, oIfmRdAddr=ifmBase+8*t+k (modulo 2^IFM_AW, wraps silently); after k=7 go to DRAIN.
REQ-023 Returned data SHALL be written into shadow slot k of the matching array via a 1-cycle delayed (enable, array, index) pipeline; weight slot 7 capture lands in the first FETCH cycle.
REQ-024 DRAIN (1 cycle, no reads): end-of-cycle edge loads oDin0..6 from shadow, oDin7 directly from iIfmRdData, oWeight0..7 from weight shadow, and sets vld_o=1 for the following cycle only.
REQ-025 After DRAIN: t increments; if t+1<iNumTile go to FETCH (k=0), else IDLE.
REQ-026 Tile period SHALL be 9 cycles; first vld_o SHALL occur 18 cycles after the iStart sample cycle (WLOAD 8 + FETCH 8 + DRAIN 1 + 1).
REQ-027 oDin*/oWeight* SHALL hold stable between vld_o pulses and after completion.
REQ-028 oDone SHALL pulse coincident with the last vld_o; oBusy SHALL be high from cycle after iStart sample through the last vld_o cycle inclusive.
REQ-029 iStart while not IDLE SHALL be ignored.
REQ-030 iClear=1 in any state: next state IDLE, rd enables low next cycle, pending capture discarded, no vld_o/oDone, operand outputs unchanged; iClear has priority over iStart.
REQ-031 Read enables SHALL never be asserted outside WLOAD/FETCH; both never asserted in the same cycle.

Reset
REQ-032 rstn low SHALL immediately force IDLE, k=t=0, all rd enables, vld_o, oBusy, oDone to 0, and oDin*/oWeight*/shadows to 0.
REQ-033 Reset assertion mid-sequence SHALL abandon the sequence; after release the block waits for a new iStart.

Verification
REQ-034 iNumTile=1, iWgtBase=0x010, iIfmBase=0x100, SRAM word=address pattern -> weight reads 0x010..0x017, ifmap reads 0x100..0x107, vld_o 18 cycles after start, oDinN=pattern(0x100+N), oDone with vld_o.
REQ-035 iNumTile=3 -> vld_o at start+18, +27, +36; third set from 0x110..0x117; exactly 3 pulses, oDone only on third.
REQ-036 iIfmBase=0xFF8, iNumTile=2 -> second tile reads 0x000..0x007 (wrap), no other change.
REQ-037 iNumTile=0 -> no read enables, oDone one cycle after start, vld_o never asserted.
REQ-038 iClear during FETCH of tile 2 of 4 -> IDLE next cycle, no further reads/vld_o, outputs retain tile-1 values; new iStart then runs normally.
REQ-039 rstn pulsed low during WLOAD -> all outputs 0 immediately; iStart during busy ignored (checked separately, no restart of addresses).
